// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exec_pkg
// Description : Shared types and constants for the SimpleRISC execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
package exec_pkg;

    localparam int XLEN = 32;

    // Dividend that overflows when divided by -1
    localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_CMP = 4'd2,
        OP_MUL = 4'd3,
        OP_DIV = 4'd4,
        OP_MOD = 4'd5,
        OP_LSL = 4'd6,
        OP_LSR = 4'd7,
        OP_ASR = 4'd8,
        OP_OR  = 4'd9,
        OP_AND = 4'd10,
        OP_NOT = 4'd11,
        OP_MOV = 4'd12
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_DIV   = 2'd2
    } exec_state_e;

endpackage
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Signed iterative restoring divider, one quotient bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
    import exec_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DIV_STEPS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            abort,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            is_mod,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(DIV_STEPS + 1);
    localparam logic [CW-1:0] c_last = CW'(DIV_STEPS);

    logic            r_busy;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_dvs;
    logic [XLEN-1:0] r_dividend;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_is_mod;
    logic            r_div_zero;
    logic            r_ovf;

    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_trial;
    logic [XLEN-1:0] w_q_signed;
    logic [XLEN-1:0] w_r_signed;

    assign w_a_neg = dividend[XLEN-1];
    assign w_b_neg = divisor[XLEN-1];
    assign w_a_mag = w_a_neg ? (~dividend + 1'b1) : dividend;
    assign w_b_mag = w_b_neg ? (~divisor + 1'b1) : divisor;

    // Partial remainder shifted left with the next dividend bit, then trial subtract
    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_trial = w_shift - {1'b0, r_dvs};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy     <= 1'b0;
            r_cnt      <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_dvs      <= '0;
            r_dividend <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_is_mod   <= 1'b0;
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (abort) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (start) begin
            r_busy     <= 1'b1;
            r_cnt      <= '0;
            r_quo      <= w_a_mag;
            r_rem      <= '0;
            r_dvs      <= w_b_mag;
            r_dividend <= dividend;
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_is_mod   <= is_mod;
            r_div_zero <= (divisor == '0);
            r_ovf      <= (dividend == INT_MIN) && (divisor == '1);
        end else if (r_busy) begin
            if (r_cnt == c_last) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
                if (!w_trial[XLEN]) begin
                    r_rem <= w_trial[XLEN-1:0];
                    r_quo <= {r_quo[XLEN-2:0], 1'b1};
                end else begin
                    r_rem <= w_shift[XLEN-1:0];
                    r_quo <= {r_quo[XLEN-2:0], 1'b0};
                end
            end
        end
    end

    assign w_q_signed = r_neg_q ? (~r_quo + 1'b1) : r_quo;
    assign w_r_signed = r_neg_r ? (~r_rem + 1'b1) : r_rem;

    always_comb begin
        result = r_is_mod ? w_r_signed : w_q_signed;
        if (r_div_zero) begin
            result = r_is_mod ? r_dividend : '0;
        end else if (r_ovf) begin
            result = r_is_mod ? '0 : INT_MIN;
        end
    end

    assign busy = r_busy;
    assign done = r_busy && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/execute_unit.sv
`default_nettype none
// ============================================================================
// Module      : execute_unit
// Description : SimpleRISC execute stage: ALU, signed divider, compare flags
//               and a valid/ready output register slice with flush.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_unit
    import exec_pkg::*;
#(
    parameter int XLEN      = exec_pkg::XLEN,
    parameter int DIV_STEPS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [XLEN-1:0] op2,
    input  logic            isLd,
    input  logic            isSt,
    input  logic            isWb,
    input  logic [3:0]      rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] aluResult,
    output logic [XLEN-1:0] op2_out,
    output logic            isLd_out,
    output logic            isSt_out,
    output logic            isWb_out,
    output logic [3:0]      rd_out,
    output logic            flagE,
    output logic            flagGT
);

    localparam int SHW = $clog2(XLEN);

    exec_state_e     r_state;
    exec_state_e     w_next;

    logic [XLEN-1:0] r_result;
    logic [XLEN-1:0] r_op2;
    logic            r_ld;
    logic            r_st;
    logic            r_wb;
    logic [3:0]      r_rd;
    logic            r_flag_e;
    logic            r_flag_gt;

    alu_op_e         w_op;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_is_div;
    logic [XLEN-1:0] w_alu;
    logic [SHW-1:0]  w_shamt;
    logic            w_div_busy;
    logic            w_div_done;
    logic [XLEN-1:0] w_div_result;

    assign w_op       = alu_op_e'(alu_op);
    assign w_shamt    = B[SHW-1:0];
    assign w_is_div   = (w_op == OP_DIV) || (w_op == OP_MOD);
    assign w_in_ready = (r_state == ST_EMPTY) || ((r_state == ST_FULL) && out_ready);
    // Inputs presented during a flush are dropped
    assign w_accept   = in_valid && w_in_ready && !flush;

    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD:  w_alu = A + B;
            OP_SUB:  w_alu = A - B;
            OP_CMP:  w_alu = A - B;
            OP_MUL:  w_alu = A * B;
            OP_LSL:  w_alu = A << w_shamt;
            OP_LSR:  w_alu = A >> w_shamt;
            OP_ASR:  w_alu = $signed(A) >>> w_shamt;
            OP_OR:   w_alu = A | B;
            OP_AND:  w_alu = A & B;
            OP_NOT:  w_alu = ~B;
            OP_MOV:  w_alu = B;
            default: w_alu = '0;
        endcase
    end

    seq_divider #(
        .XLEN      (XLEN),
        .DIV_STEPS (DIV_STEPS)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .abort    (flush),
        .start    (w_accept && w_is_div),
        .dividend (A),
        .divisor  (B),
        .is_mod   (w_op == OP_MOD),
        .busy     (w_div_busy),
        .done     (w_div_done),
        .result   (w_div_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) w_next = w_is_div ? ST_DIV : ST_FULL;
            end
            ST_FULL: begin
                if (w_accept)       w_next = w_is_div ? ST_DIV : ST_FULL;
                else if (out_ready) w_next = ST_EMPTY;
            end
            ST_DIV: begin
                // Recover if the divider is ever idle without having finished
                if (w_div_done)       w_next = ST_FULL;
                else if (!w_div_busy) w_next = ST_EMPTY;
            end
            default: w_next = ST_EMPTY;
        endcase
        if (flush) w_next = ST_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result  <= '0;
            r_op2     <= '0;
            r_ld      <= 1'b0;
            r_st      <= 1'b0;
            r_wb      <= 1'b0;
            r_rd      <= '0;
            r_flag_e  <= 1'b0;
            r_flag_gt <= 1'b0;
        end else if (!flush) begin
            if (w_accept) begin
                r_op2 <= op2;
                r_ld  <= isLd;
                r_st  <= isSt;
                r_wb  <= isWb;
                r_rd  <= rd;
                if (!w_is_div) r_result <= w_alu;
                if (w_op == OP_CMP) begin
                    r_flag_e  <= (A == B);
                    r_flag_gt <= ($signed(A) > $signed(B));
                end
            end else if ((r_state == ST_DIV) && w_div_done) begin
                r_result <= w_div_result;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = (r_state == ST_FULL);
    assign aluResult = r_result;
    assign op2_out   = r_op2;
    assign isLd_out  = r_ld;
    assign isSt_out  = r_st;
    assign isWb_out  = r_wb;
    assign rd_out    = r_rd;
    assign flagE     = r_flag_e;
    assign flagGT    = r_flag_gt;

endmodule
`default_nettype wire

// File: tb/tb_execute_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_unit
// Description : Directed scoreboard bench for execute_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_unit;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  alu_op, rd, rd_out;
    logic [31:0] A, B, op2, aluResult, op2_out;
    logic        isLd, isSt, isWb, isLd_out, isSt_out, isWb_out, flagE, flagGT;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] op2;
        logic [6:0]  ctl;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic last_valid;

    execute_unit #(.XLEN(32), .DIV_STEPS(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
        .A(A), .B(B), .op2(op2), .isLd(isLd), .isSt(isSt), .isWb(isWb), .rd(rd),
        .out_valid(out_valid), .out_ready(out_ready), .aluResult(aluResult),
        .op2_out(op2_out), .isLd_out(isLd_out), .isSt_out(isSt_out),
        .isWb_out(isWb_out), .rd_out(rd_out), .flagE(flagE), .flagGT(flagGT)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every completed handshake must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", {31'd0, out_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", aluResult, e.res);
                check("op2_out", op2_out, e.op2);
                check("ctl", {25'd0, isLd_out, isSt_out, isWb_out, rd_out}, {25'd0, e.ctl});
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] d, input logic ld, input logic st, input logic wb,
                        input logic [3:0] r, input logic [31:0] exp_res, input bit track);
        int n;
        alu_op = op; A = a; B = b; op2 = d; isLd = ld; isSt = st; isWb = wb; rd = r;
        in_valid = 1'b1;
        if (track) sb.push_back('{res: exp_res, op2: d, ctl: {ld, st, wb, r}});
        n = 0;
        @(negedge clk);
        last_valid = out_valid;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic div_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res);
        int k;
        bit ready_seen;
        ready_seen = 1'b0;
        send(op, a, b, 32'h0000_D1D0, 1'b0, 1'b0, 1'b1, 4'd7, exp_res, 1'b1);
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (out_valid) break;
            if (in_ready) ready_seen = 1'b1;
        end
        check("div_latency", k, 34);
        check("div_in_ready_low", {31'd0, ready_seen}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        bit seen;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = 4'd0; A = '0; B = '0; op2 = '0; isLd = 1'b0; isSt = 1'b0; isWb = 1'b0; rd = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_aluResult", aluResult, 32'd0);
        check("rst_op2_out", op2_out, 32'd0);
        check("rst_ctl", {25'd0, isLd_out, isSt_out, isWb_out, rd_out}, 32'd0);
        check("rst_flags", {30'd0, flagE, flagGT}, 32'd0);
        @(posedge clk); #1;

        // Back-to-back single-cycle ops
        send(4'd0, 32'd5, 32'd7, 32'h11, 1'b0, 1'b0, 1'b1, 4'd1, 32'd12, 1'b1);
        check("b2b_valid0", {31'd0, last_valid}, 32'd0);
        send(4'd1, 32'd3, 32'd5, 32'h22, 1'b0, 1'b0, 1'b1, 4'd2, 32'hFFFF_FFFE, 1'b1);
        check("b2b_valid1", {31'd0, last_valid}, 32'd1);
        send(4'd8, 32'h8000_0000, 32'd4, 32'h33, 1'b0, 1'b0, 1'b1, 4'd3, 32'hF800_0000, 1'b1);
        check("b2b_valid2", {31'd0, last_valid}, 32'd1);
        check("b2b_valid3", {31'd0, out_valid}, 32'd1);

        // Remaining single-cycle opcodes
        send(4'd3, 32'h0001_0000, 32'h0001_0001, 32'h0, 1'b0, 1'b0, 1'b1, 4'd4, 32'h0001_0000, 1'b1);
        send(4'd6, 32'h0000_00F1, 32'd36, 32'h0, 1'b0, 1'b0, 1'b1, 4'd4, 32'h0000_0F10, 1'b1);
        send(4'd7, 32'h8000_0000, 32'd31, 32'h0, 1'b0, 1'b0, 1'b1, 4'd4, 32'h0000_0001, 1'b1);
        send(4'd9, 32'hF000_000F, 32'h0FF0_0000, 32'h0, 1'b0, 1'b0, 1'b1, 4'd4, 32'hFFF0_000F, 1'b1);
        send(4'd10, 32'hF000_000F, 32'h1000_00FF, 32'h0, 1'b0, 1'b0, 1'b1, 4'd4, 32'h1000_000F, 1'b1);
        send(4'd11, 32'h1234_5678, 32'h0000_FFFF, 32'h0, 1'b0, 1'b0, 1'b1, 4'd4, 32'hFFFF_0000, 1'b1);
        send(4'd14, 32'h1234_5678, 32'h0000_FFFF, 32'h0, 1'b0, 1'b1, 1'b0, 4'd4, 32'h0, 1'b1);

        // Compare flags
        send(4'd2, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'hFFFF_FFFE, 1'b1);
        check("cmp_m1_1_flags", {30'd0, flagE, flagGT}, 32'd0);
        send(4'd2, 32'd5, 32'hFFFF_FFFD, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd8, 1'b1);
        check("cmp_5_m3_flags", {30'd0, flagE, flagGT}, 32'd1);
        send(4'd2, 32'd9, 32'd9, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
        check("cmp_9_9_flags", {30'd0, flagE, flagGT}, 32'd2);
        send(4'd0, 32'd1, 32'd1, 32'h0, 1'b0, 1'b0, 1'b1, 4'd5, 32'd2, 1'b1);
        check("add_keeps_flags", {30'd0, flagE, flagGT}, 32'd2);

        // Signed divides and corner cases
        div_op(4'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        div_op(4'd5, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        div_op(4'd4, 32'd10, 32'd0, 32'd0);
        div_op(4'd5, 32'd10, 32'd0, 32'd10);
        div_op(4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        div_op(4'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        div_op(4'd5, 32'd7, 32'hFFFF_FFFE, 32'd1);
        div_op(4'd4, 32'd1000, 32'd7, 32'd142);
        check("div_keeps_flags", {30'd0, flagE, flagGT}, 32'd2);

        // Back-pressure with a load bundle held
        out_ready = 1'b0;
        send(4'd0, 32'h100, 32'd4, 32'h0000_ABCD, 1'b1, 1'b0, 1'b1, 4'd3, 32'h104, 1'b1);
        alu_op = 4'd12; A = 32'd0; B = 32'h77; op2 = 32'h5; isLd = 1'b0; isSt = 1'b0; isWb = 1'b1; rd = 4'd5;
        in_valid = 1'b1;
        sb.push_back('{res: 32'h77, op2: 32'h5, ctl: {1'b0, 1'b0, 1'b1, 4'd5}});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_result", aluResult, 32'h104);
            check("hold_ld_rd", {27'd0, isLd_out, rd_out}, {27'd0, 1'b1, 4'd3});
            check("hold_op2", op2_out, 32'h0000_ABCD);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Flush in the middle of a divide
        send(4'd4, 32'd100, 32'd3, 32'h0, 1'b0, 1'b0, 1'b1, 4'd6, 32'd33, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        alu_op = 4'd12; B = 32'h99; in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        check("flush_flags", {30'd0, flagE, flagGT}, 32'd2);
        seen = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("flush_no_stale", {31'd0, seen}, 32'd0);
        @(posedge clk); #1;
        send(4'd12, 32'd0, 32'h55, 32'h0, 1'b0, 1'b0, 1'b1, 4'd8, 32'h55, 1'b1);

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", sb.size(), 32'd0);
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
